// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states and the trap check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Illegal size codes trap the same way as misaligned addresses.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated store data, plus load lane extraction and extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_lane_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        st_be        = '0;
        st_lane_data = st_wdata;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_be        = BE_W'(4'b0001) << st_off;
                st_lane_data = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be        = BE_W'(4'b0011) << st_off;
                st_lane_data = {2{st_wdata[15:0]}};
            end
            F3_W:    st_be = '1;
            default: st_be = '0;
        endcase
    end

    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'b0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request/grant/response handshake to data memory with alignment trapping.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              mis_q, mis_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_lane_data;
    logic [DATA_W-1:0] ld_data;
    logic              capture;

    lsu_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .st_funct3   (lsu_funct3),
        .st_off      (lsu_addr[1:0]),
        .st_wdata    (lsu_wdata),
        .st_be       (st_be),
        .st_lane_data(st_lane_data),
        .ld_funct3   (funct3_q),
        .ld_off      (off_q),
        .ld_word     (mem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        mis_d    = mis_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        capture  = 1'b0;
        mem_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lsu_valid) begin
                    we_d     = lsu_we;
                    funct3_d = lsu_funct3;
                    off_d    = lsu_addr[1:0];
                    mis_d    = is_misaligned(lsu_funct3, lsu_addr[1:0]);
                    if (mis_d) begin
                        state_d = StResp;
                    end else begin
                        state_d = StReq;
                        addr_d  = {lsu_addr[ADDR_W-1:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_lane_data;
                    end
                end
            end
            StReq: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = StResp;
                    end else if (mem_rvalid) begin
                        capture = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            rdata_d = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            mis_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    assign misaligned = done & mis_q;
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected completions.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        busy, done, misaligned, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    load_store_unit #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .lsu_we    (lsu_we),
        .lsu_funct3(lsu_funct3),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .misaligned(misaligned),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " misaligned"}, 32'(misaligned), 0);
        check({tag, " mem_req"}, 32'(mem_req), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " rdata"}, rdata, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " mem_be"}, 32'(mem_be), 0);
    endtask

    // One access; memory grants after gnt_dly REQ cycles and returns data rv_dly cycles after gnt.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rword,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic exp_mis, input logic [31:0] exp_rd);
        exp_t e;
        bit   seen_done = 1'b0;
        int   lat;
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle done"}, 32'(done), 0);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        mem_rdata  = rword;
        lat = exp_mis ? 1 : (we ? 2 + gnt_dly : 2 + gnt_dly + rv_dly);
        e = '{mis: exp_mis, rd: exp_rd, lat: lat};
        sb_q.push_back(e);
        @(posedge clk);
        for (int k = 1; k <= 20 && !seen_done; k++) begin
            @(negedge clk);
            lsu_valid  = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                check({tag, " scoreboard nonempty"}, 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check({tag, " misaligned"}, 32'(misaligned), 32'(e.mis));
                    check({tag, " rdata"}, rdata, e.rd);
                    check({tag, " latency"}, 32'(k), 32'(e.lat));
                end
                check({tag, " resp mem_req"}, 32'(mem_req), 0);
                check({tag, " resp busy"}, 32'(busy), 0);
            end else if (!exp_mis && k <= 1 + gnt_dly) begin
                check({tag, " req mem_req"}, 32'(mem_req), 1);
                check({tag, " req busy"}, 32'(busy), 1);
                check({tag, " req mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                check({tag, " req mem_be"}, 32'(mem_be), 32'(exp_be));
                check({tag, " req mem_we"}, 32'(mem_we), 32'(we));
                if (we) check({tag, " req mem_wdata"}, mem_wdata, exp_wd);
                if (k == 1 + gnt_dly) mem_gnt = 1'b1;
                if (!we && k == 1 + gnt_dly + rv_dly) mem_rvalid = 1'b1;
            end else begin
                check({tag, " wait mem_req"}, 32'(mem_req), 0);
                if (!exp_mis) check({tag, " wait busy"}, 32'(busy), 1);
                if (!we && !exp_mis && k == 1 + gnt_dly + rv_dly) mem_rvalid = 1'b1;
            end
        end
        if (!seen_done) check({tag, " done timeout"}, 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;

        access("sw", 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
               4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        access("sb", 1'b1, F3_B, 32'h103, 32'h000000A5, 0, 0, 32'h0,
               4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0);
        access("lb", 1'b0, F3_B, 32'h102, 32'h0, 0, 1, 32'h12F03456,
               4'b0100, 32'h0, 1'b0, 32'hFFFFFFF0);
        access("lbu", 1'b0, F3_BU, 32'h102, 32'h0, 0, 1, 32'h12F03456,
               4'b0100, 32'h0, 1'b0, 32'h000000F0);
        access("lh_mis", 1'b0, F3_H, 32'h201, 32'h0, 0, 0, 32'h0,
               4'b0000, 32'h0, 1'b1, 32'h000000F0);
        access("lw_stall", 1'b0, F3_W, 32'h300, 32'h0, 4, 1, 32'h80000001,
               4'b1111, 32'h0, 1'b0, 32'h80000001);
        access("lh_same", 1'b0, F3_H, 32'h102, 32'h0, 0, 0, 32'h80011234,
               4'b1100, 32'h0, 1'b0, 32'hFFFF8001);
        access("lhu", 1'b0, F3_HU, 32'h100, 32'h0, 1, 0, 32'h1234F00F,
               4'b0011, 32'h0, 1'b0, 32'h0000F00F);
        access("sh", 1'b1, F3_H, 32'h102, 32'h0000BEEF, 2, 0, 32'h0,
               4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0000F00F);
        access("illegal_f3", 1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0,
               4'b0000, 32'h0, 1'b1, 32'h0000F00F);
        access("sw_mis", 1'b1, F3_W, 32'h102, 32'h11223344, 0, 0, 32'h0,
               4'b0000, 32'h0, 1'b1, 32'h0000F00F);

        // Reset while a load waits for its data; the late rvalid must be ignored.
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_we     = 1'b0;
        lsu_funct3 = F3_W;
        lsu_addr   = 32'h400;
        @(posedge clk);
        @(negedge clk);
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_wait busy", 32'(busy), 1);
        check("rst_wait mem_req", 32'(mem_req), 0);
        #2 rst = 1'b0;
        #1 check_reset("async reset");
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst done", 32'(done), 0);
            check("post_rst busy", 32'(busy), 0);
            check("post_rst rdata", rdata, 0);
            @(negedge clk);
        end

        check("scoreboard drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address, plus the store operand and funct3 size code.
- Runs a request/grant/response handshake to data memory and returns sign- or zero-extended load data for writeback.
- While an access is in flight it stalls the core via busy.
- Misaligned accesses are trapped without touching memory.

Parameters:
- ADDR_W, 32, width of effective address and mem_addr
- DATA_W, 32, data width; fixed at 32, byte enables are DATA_W/8 = 4

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- lsu_valid  in  1  access request from the execute stage, sampled only in IDLE
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- lsu_addr  in  32  effective address (ALU result)
- lsu_wdata  in  32  store operand (rs2)
- busy  out  1  stall to the core
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid when done=1 and the access was a load
- misaligned  out  1  one-cycle trap pulse, coincident with done
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address, lsu_addr with bits [1:0] = 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset (rst=0, async): state=IDLE. busy, done, misaligned, mem_req, mem_we = 0. rdata, mem_addr, mem_wdata = 0. mem_be = 0000.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - lsu_valid=1 latches we, funct3 and addr[1:0]. Next state is REQ and busy=1 from the next cycle.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=00) goes to RESP with misaligned set. No mem_req is issued.
  - Illegal funct3 (011, 110, 111) is handled as misaligned (trap).
- REQ:
  - mem_req=1, and mem_addr/mem_be/mem_wdata/mem_we are held stable until mem_gnt=1.
  - Store + gnt goes to RESP. Load + gnt goes to WAIT.
  - Load with gnt and rvalid in the same cycle goes straight to RESP with data captured.
- WAIT: mem_req=0. Waits for mem_rvalid, captures mem_rdata, then goes to RESP. No timeout.
- RESP:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - lsu_valid in the RESP cycle is ignored. A back-to-back access is accepted on the following IDLE cycle, so minimum spacing is 1 idle cycle.
- busy=1 in REQ and WAIT only.
- Latency with gnt/rvalid immediate:
  - store: done 2 cycles after accept
  - load with gnt and rvalid in the same cycle: done 2 cycles after accept
  - load with rvalid one cycle after gnt: done 3 cycles after accept
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Load extraction:
  - select the byte/half lane by the latched addr[1:0]
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend
  - rdata holds its value until the next load completes
- Stores and traps leave rdata unchanged.
- Reset mid-access: returns to IDLE immediately and drops mem_req. The in-flight response is not tracked.
- The memory side must not assert rvalid after that reset.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (2-bit enum)
  - byte-enable width constant
- One sub-module: lsu_align, purely combinational. It covers be/wdata lane generation for stores and rdata extraction/extension for loads.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in REQ's first cycle -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF; done 2 cycles after accept; rdata unchanged.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x102, mem_rdata=0x12F03456 with rvalid one cycle after gnt -> rdata=0xFFFFFFF0 and done on the 3rd cycle after accept. LBU on the same data -> rdata=0x000000F0.
- LH addr=0x201 -> misaligned=1 and done=1 in the same cycle, mem_req never asserted, rdata unchanged.
- LW with gnt held low 4 cycles -> mem_req, mem_addr and be stable for all 4 cycles, busy=1 throughout; after rvalid with 0x80000001, rdata=0x80000001.
- rst driven low while in WAIT -> all outputs go to reset values asynchronously; a later rvalid is ignored and state stays IDLE.
